sm_0535_uart_tx_arbiter: RTL and testbench

Shares the bot's single UART transmitter between several message sources: the colour/unit reporter, the status reporter and the debug path. Each source streams one message byte by byte with a last flag. The arbiter grants sources round-robin, one whole message at a time, and forwards each byte to the UART TX core using that core's valid/done handshake. It optionally appends the 0x0D terminator, and a watchdog aborts a message if the TX core stops responding. It sits between the message-generating controllers and the UART TX core.

---
 rtl/sm_0535_uart_pkg.sv | 34 +++
 rtl/sm_0535_uart_tx_arbiter_rr_pick.sv | 30 +++
 rtl/sm_0535_uart_tx_arbiter.sv | 167 ++++++++++++++++
 tb/tb_sm_0535_uart_tx_arbiter.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sm_0535_uart_pkg.sv
// Shared definitions for the UART TX arbiter and the message generators
// that feed it: FSM state encoding, the terminator byte, colour/unit codes
// and a small round-robin helper.
package sm_0535_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SEND  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_TERM  = 3'd4,
        ST_TWAIT = 3'd5,
        ST_DONE  = 3'd6
    } state_t;

    localparam logic [7:0] CR_BYTE = 8'h0D;

    // Colour codes reported by the colour/unit reporter.
    localparam logic [2:0] COLOUR_RED   = 3'b001;
    localparam logic [2:0] COLOUR_BLUE  = 3'b010;
    localparam logic [2:0] COLOUR_GREEN = 3'b100;

    // Unit codes shared with the message generators.
    localparam logic [2:0] UNIT_MPU = 3'd1;
    localparam logic [2:0] UNIT_W   = 3'd2;
    localparam logic [2:0] UNIT_SSU = 3'd3;
    localparam logic [2:0] UNIT_PU  = 3'd4;

    // Index following idx in a ring of n requesters.
    function automatic int next_index(input int idx, input int n);
        return (idx + 1) % n;
    endfunction

endpackage

// File: rtl/sm_0535_uart_tx_arbiter_rr_pick.sv
// Combinational round-robin selector: starting at rr_ptr and wrapping,
// returns the first valid requester as a one-hot pick plus a found flag.
module sm_0535_rr_pick
    import sm_0535_uart_pkg::*;
#(
    parameter int N_REQ = 3,
    parameter int PTR_W = 2
) (
    input  logic [N_REQ-1:0] req_valid,
    input  logic [PTR_W-1:0] rr_ptr,
    output logic [N_REQ-1:0] pick,
    output logic             found
);

    // Walk the ring from rr_ptr and latch onto the first valid requester.
    always_comb begin
        logic [PTR_W-1:0] idx;
        pick  = '0;
        found = 1'b0;
        idx   = '0;
        for (int off = 0; off < N_REQ; off++) begin
            idx = PTR_W'((int'(rr_ptr) + off) % N_REQ);
            if (!found && req_valid[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sm_0535_uart_tx_arbiter.sv
// Shares one UART transmitter between N_REQ message sources. Whole messages
// are granted round-robin; each byte is handed to the TX core with a
// valid/done handshake, an optional CR terminator follows the last byte, and
// a per-byte watchdog aborts a message when the TX core stops answering.
module sm_0535_uart_tx_arbiter
    import sm_0535_uart_pkg::*;
#(
    parameter int N_REQ       = 3,
    parameter int TIMEOUT_CYC = 65535,
    parameter int APPEND_CR   = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_byte,
    input  logic [N_REQ-1:0]   req_last,
    output logic [N_REQ-1:0]   req_ready,
    output logic [N_REQ-1:0]   grant,
    output logic               tx_data_valid,
    output logic [7:0]         tx_byte,
    input  logic               o_tx_done,
    output logic               busy,
    output logic               timeout_err
);

    localparam int PTR_W   = $clog2(N_REQ);
    localparam int TIMER_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TIMER_W-1:0] TIMER_LIMIT = TIMER_W'(TIMEOUT_CYC - 1);
    localparam bit USE_CR = (APPEND_CR != 0);

    state_t             state;
    state_t             state_nx;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   owner;
    logic [PTR_W-1:0]   pick_idx;
    logic [TIMER_W-1:0] timer;
    logic               last_q;
    logic [N_REQ-1:0]   pick;
    logic               found;
    logic               own_valid;
    logic               own_last;
    logic [7:0]         own_byte;
    logic               at_limit;

    sm_0535_rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr),
        .pick      (pick),
        .found     (found)
    );

    // The owner's lane, selected through the registered grant.
    assign own_valid = |(grant & req_valid);
    assign own_last  = |(grant & req_last);
    assign own_byte  = req_byte[{owner, 3'b000} +: 8];
    assign at_limit  = (timer == TIMER_LIMIT);

    // Binary index of the one-hot pick, remembered as the message owner.
    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick[i]) pick_idx = PTR_W'(i);
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nx;
    end

    // Next-state logic and handshake strobes; done beats the watchdog limit.
    always_comb begin
        state_nx      = state;
        req_ready     = '0;
        tx_data_valid = 1'b0;
        timeout_err   = 1'b0;
        busy          = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (found) state_nx = ST_LOAD;
            end
            ST_LOAD: begin
                req_ready = grant & req_valid;
                if (own_valid) state_nx = ST_SEND;
            end
            ST_SEND: begin
                tx_data_valid = 1'b1;
                state_nx      = ST_WAIT;
            end
            ST_WAIT: begin
                if (o_tx_done) begin
                    if (!last_q)     state_nx = ST_LOAD;
                    else if (USE_CR) state_nx = ST_TERM;
                    else             state_nx = ST_DONE;
                end else if (at_limit) begin
                    timeout_err = 1'b1;
                    state_nx    = ST_DONE;
                end
            end
            ST_TERM: begin
                tx_data_valid = 1'b1;
                state_nx      = ST_TWAIT;
            end
            ST_TWAIT: begin
                if (o_tx_done) begin
                    state_nx = ST_DONE;
                end else if (at_limit) begin
                    timeout_err = 1'b1;
                    state_nx    = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // Grant, round-robin pointer, byte capture and per-byte watchdog timer.
    always_ff @(posedge clk) begin
        if (reset) begin
            grant   <= '0;
            rr_ptr  <= '0;
            owner   <= '0;
            tx_byte <= 8'h00;
            last_q  <= 1'b0;
            timer   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (found) begin
                        grant <= pick;
                        owner <= pick_idx;
                    end
                end
                ST_LOAD: begin
                    if (own_valid) begin
                        tx_byte <= own_byte;
                        last_q  <= own_last;
                    end
                end
                ST_SEND, ST_TERM: begin
                    timer <= '0;
                end
                ST_WAIT, ST_TWAIT: begin
                    if (!o_tx_done && !at_limit) timer <= timer + 1'b1;
                    // The terminator is staged so it is on tx_byte during TERM.
                    if (state == ST_WAIT && o_tx_done && last_q && USE_CR)
                        tx_byte <= CR_BYTE;
                end
                ST_DONE: begin
                    grant  <= '0;
                    rr_ptr <= PTR_W'(next_index(int'(owner), N_REQ));
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sm_0535_uart_tx_arbiter.sv
// Testbench for sm_0535_uart_tx_arbiter. Three instances cover the default
// configuration, a short watchdog and no terminator; the unused ones are
// held in reset. Requesters and the TX core are modelled in a driver process;
// expected byte streams come from a message-level round-robin model.
`timescale 1ns/1ps
module tb_sm_0535_uart_tx_arbiter;

    localparam int N = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst = 1'b1;
    int           sel = 0;
    logic [N-1:0] req_valid;
    logic [8*N-1:0] req_byte;
    logic [N-1:0] req_last;
    logic [N-1:0] stall = '0;
    logic         core_done;
    logic         extra_done = 1'b0;
    logic         core_mute = 1'b0;
    int           done_dly = 4;
    logic         done_in;
    assign done_in = core_done | extra_done;

    // Per-instance gated inputs and outputs
    logic rst_a, rst_b, rst_c, done_a, done_b, done_c;
    logic [N-1:0] val_a, val_b, val_c;
    logic [N-1:0] rdy_a, rdy_b, rdy_c, gr_a, gr_b, gr_c;
    logic dv_a, dv_b, dv_c, busy_a, busy_b, busy_c, te_a, te_b, te_c;
    logic [7:0] tb_a, tb_b, tb_c;

    assign rst_a  = rst | (sel != 0);
    assign rst_b  = rst | (sel != 1);
    assign rst_c  = rst | (sel != 2);
    assign val_a  = (sel == 0) ? req_valid : '0;
    assign val_b  = (sel == 1) ? req_valid : '0;
    assign val_c  = (sel == 2) ? req_valid : '0;
    assign done_a = (sel == 0) & done_in;
    assign done_b = (sel == 1) & done_in;
    assign done_c = (sel == 2) & done_in;

    sm_0535_uart_tx_arbiter #(.N_REQ(3), .TIMEOUT_CYC(65535), .APPEND_CR(1)) dut (
        .clk(clk), .reset(rst_a), .req_valid(val_a), .req_byte(req_byte), .req_last(req_last),
        .req_ready(rdy_a), .grant(gr_a), .tx_data_valid(dv_a), .tx_byte(tb_a),
        .o_tx_done(done_a), .busy(busy_a), .timeout_err(te_a));

    sm_0535_uart_tx_arbiter #(.N_REQ(3), .TIMEOUT_CYC(16), .APPEND_CR(1)) dut_to (
        .clk(clk), .reset(rst_b), .req_valid(val_b), .req_byte(req_byte), .req_last(req_last),
        .req_ready(rdy_b), .grant(gr_b), .tx_data_valid(dv_b), .tx_byte(tb_b),
        .o_tx_done(done_b), .busy(busy_b), .timeout_err(te_b));

    sm_0535_uart_tx_arbiter #(.N_REQ(3), .TIMEOUT_CYC(64), .APPEND_CR(0)) dut_nocr (
        .clk(clk), .reset(rst_c), .req_valid(val_c), .req_byte(req_byte), .req_last(req_last),
        .req_ready(rdy_c), .grant(gr_c), .tx_data_valid(dv_c), .tx_byte(tb_c),
        .o_tx_done(done_c), .busy(busy_c), .timeout_err(te_c));

    logic [N-1:0] obs_ready, obs_grant;
    logic obs_dv, obs_busy, obs_terr;
    logic [7:0] obs_byte;

    always_comb begin
        obs_ready = rdy_a; obs_grant = gr_a; obs_dv = dv_a;
        obs_busy = busy_a; obs_terr = te_a; obs_byte = tb_a;
        if (sel == 1) begin
            obs_ready = rdy_b; obs_grant = gr_b; obs_dv = dv_b;
            obs_busy = busy_b; obs_terr = te_b; obs_byte = tb_b;
        end else if (sel == 2) begin
            obs_ready = rdy_c; obs_grant = gr_c; obs_dv = dv_c;
            obs_busy = busy_c; obs_terr = te_c; obs_byte = tb_c;
        end
    end

    // Requester queues: {last, byte}; per-round message record for the model
    logic [8:0]  q0[$], q1[$], q2[$];
    logic [7:0]  rm0[$], rm1[$], rm2[$];
    logic [N-1:0] has = '0;
    logic [10:0] sent_q[$], exp_q[$];
    int n_timeout = 0;
    int mptr = 0;
    int n_assert = 0;
    int n_fail = 0;

    function automatic int qsize(input int i);
        case (i)
            0: return q0.size();
            1: return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic logic [8:0] qfront(input int i);
        if (qsize(i) == 0) return 9'h000;
        case (i)
            0: return q0[0];
            1: return q1[0];
            default: return q2[0];
        endcase
    endfunction

    function automatic int rm_len(input int i);
        case (i)
            0: return rm0.size();
            1: return rm1.size();
            default: return rm2.size();
        endcase
    endfunction

    function automatic logic [7:0] rm_get(input int i, input int k);
        case (i)
            0: return rm0[k];
            1: return rm1[k];
            default: return rm2[k];
        endcase
    endfunction

    // Requester and TX-core models: sample at negedge, drive just after posedge
    initial begin
        logic [N-1:0] rdy_s, gr_s;
        logic dv_s, te_s, rst_s;
        logic [7:0] byte_s;
        logic [8:0] f;
        int cnt;
        cnt = 0; core_done = 1'b0; req_valid = '0; req_byte = '0; req_last = '0;
        forever begin
            @(negedge clk);
            rdy_s = obs_ready; gr_s = obs_grant; dv_s = obs_dv;
            te_s = obs_terr; byte_s = obs_byte; rst_s = rst;
            if (dv_s) sent_q.push_back({gr_s, byte_s});
            if (te_s) n_timeout++;
            @(posedge clk);
            #1;
            if (rdy_s[0] && q0.size() > 0) void'(q0.pop_front());
            if (rdy_s[1] && q1.size() > 0) void'(q1.pop_front());
            if (rdy_s[2] && q2.size() > 0) void'(q2.pop_front());
            for (int i = 0; i < N; i++) begin
                f = qfront(i);
                req_valid[i] = (qsize(i) > 0) && !stall[i];
                req_byte[8*i +: 8] = f[7:0];
                req_last[i] = f[8];
            end
            core_done = 1'b0;
            if (rst_s) begin
                cnt = 0;
            end else begin
                if (dv_s && !core_mute) cnt = done_dly;
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) core_done = 1'b1;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_one(input int i, input logic [7:0] b, input logic last);
        case (i)
            0: begin q0.push_back({last, b}); rm0.push_back(b); end
            1: begin q1.push_back({last, b}); rm1.push_back(b); end
            default: begin q2.push_back({last, b}); rm2.push_back(b); end
        endcase
        has[i] = 1'b1;
    endtask

    task automatic push_msg(input int i, input int len);
        for (int k = 0; k < len; k++)
            push_one(i, 8'($urandom_range(0, 255)), k == len - 1);
    endtask

    task automatic clear_round();
        rm0.delete(); rm1.delete(); rm2.delete(); has = '0;
    endtask

    // Message-level model: owners in ring order from the pointer, whole messages
    task automatic model_round(input bit use_cr);
        int idx, last_idx;
        logic [2:0] oh;
        last_idx = -1;
        for (int k = 0; k < N; k++) begin
            idx = (mptr + k) % N;
            if (has[idx]) begin
                oh = 3'(1 << idx);
                for (int j = 0; j < rm_len(idx); j++) exp_q.push_back({oh, rm_get(idx, j)});
                if (use_cr) exp_q.push_back({oh, 8'h0D});
                last_idx = idx;
            end
        end
        if (last_idx >= 0) mptr = (last_idx + 1) % N;
        clear_round();
    endtask

    task automatic check_sent(input string tag);
        check({tag, "_count"}, 32'(sent_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < sent_q.size(); i++)
            check($sformatf("%s_b%0d", tag, i), 32'(sent_q[i]), 32'(exp_q[i]));
        sent_q.delete();
        exp_q.delete();
    endtask

    task automatic wait_idle(input int max_cyc, input string tag);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge clk);
            if (q0.size() == 0 && q1.size() == 0 && q2.size() == 0 && obs_busy == 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, "_idle"}, 32'(ok), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_grant"}, 32'(obs_grant), 32'd0);
        check({tag, "_ready"}, 32'(obs_ready), 32'd0);
        check({tag, "_dv"},    32'(obs_dv),    32'd0);
        check({tag, "_terr"},  32'(obs_terr),  32'd0);
        check({tag, "_busy"},  32'(obs_busy),  32'd0);
        check({tag, "_byte"},  32'(obs_byte),  32'd0);
    endtask

    task automatic do_reset(input int which);
        rst = 1'b1;
        sel = which;
        stall = '0;
        extra_done = 1'b0;
        core_mute = 1'b0;
        q0.delete(); q1.delete(); q2.delete();
        clear_round();
        cyc(3);
        sent_q.delete(); exp_q.delete();
        n_timeout = 0;
        mptr = 0;
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, observed hang expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        string msg;
        int seen, k_to, bad, ok;
        logic [7:0] m0 [3];
        logic [7:0] m1 [2];

        // Reset state
        sel = 0; rst = 1'b1;
        cyc(3);
        check_reset_outputs("rst");

        // Single message "SI-W-CT-#" with latency checks
        do_reset(0);
        done_dly = 20;
        msg = "SI-W-CT-#";
        for (int i = 0; i < msg.len(); i++) push_one(0, msg[i], i == msg.len() - 1);
        model_round(1'b1);
        @(negedge clk);
        check("lat0_grant", 32'(obs_grant), 32'd0);
        @(negedge clk);
        check("lat1_grant", 32'(obs_grant), 32'b001);
        check("lat1_ready", 32'(obs_ready), 32'b001);
        @(negedge clk);
        check("lat2_dv",   32'(obs_dv),   32'd1);
        check("lat2_byte", 32'(obs_byte), 32'h53);
        @(negedge clk);
        check("lat3_dv",   32'(obs_dv),   32'd0);
        check("lat3_busy", 32'(obs_busy), 32'd1);
        wait_idle(2000, "single");
        check_sent("single");
        check("single_grant_rel", 32'(obs_grant), 32'd0);

        // Contention: all three at once, then 2 and 0
        do_reset(0);
        done_dly = 4;
        for (int i = 0; i < N; i++) push_msg(i, $urandom_range(1, 4));
        model_round(1'b1);
        wait_idle(1000, "cont1");
        check("cont1_first_owner", 32'(sent_q[0][10:8]), 32'b001);
        check_sent("cont1");
        push_msg(2, 3);
        push_msg(0, 2);
        model_round(1'b1);
        wait_idle(1000, "cont2");
        check("cont2_first_owner", 32'(sent_q[0][10:8]), 32'b001);
        check("cont2_last_owner", 32'(sent_q[sent_q.size()-1][10:8]), 32'b100);
        check_sent("cont2");

        // Randomised rounds
        for (int r = 0; r < 6; r++) begin
            done_dly = $urandom_range(1, 5);
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 1) == 1 || (r == 5 && i == 1)) push_msg(i, $urandom_range(1, 5));
            model_round(1'b1);
            wait_idle(1500, $sformatf("rnd%0d", r));
            check_sent($sformatf("rnd%0d", r));
        end

        // Stall: requester 1 drops valid mid-message
        do_reset(0);
        done_dly = 3;
        push_msg(1, 6);
        model_round(1'b1);
        seen = 0;
        for (int c = 0; c < 200 && seen < 3; c++) begin
            @(negedge clk);
            if (obs_dv) seen++;
        end
        check("stall_reach3", 32'(seen), 32'd3);
        stall[1] = 1'b1;
        cyc(10);
        check("stall_grant", 32'(obs_grant), 32'b010);
        check("stall_busy",  32'(obs_busy),  32'd1);
        check("stall_ready", 32'(obs_ready), 32'd0);
        bad = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (obs_dv || obs_grant != 3'b010) bad++;
        end
        check("stall_hold", 32'(bad), 32'd0);
        stall[1] = 1'b0;
        wait_idle(500, "stall");
        check_sent("stall");

        // Timeout with TIMEOUT_CYC=16, TX core silent
        do_reset(1);
        core_mute = 1'b1;
        for (int k = 0; k < 3; k++) begin m0[k] = 8'($urandom_range(0, 255)); push_one(0, m0[k], k == 2); end
        for (int k = 0; k < 2; k++) begin m1[k] = 8'($urandom_range(0, 255)); push_one(1, m1[k], k == 1); end
        clear_round();
        ok = 0;
        for (int c = 0; c < 20 && ok == 0; c++) begin
            @(negedge clk);
            if (obs_dv) ok = 1;
        end
        check("to_first_send", 32'(ok), 32'd1);
        k_to = 0;
        for (int c = 1; c <= 40 && k_to == 0; c++) begin
            @(negedge clk);
            if (obs_terr) k_to = c;
        end
        check("to_delay", 32'(k_to), 32'd16);
        @(negedge clk);
        check("to_pulse_width", 32'(obs_terr), 32'd0);
        @(negedge clk);
        check("to_released", 32'(obs_grant), 32'd0);
        @(negedge clk);
        check("to_next_owner", 32'(obs_grant), 32'b010);
        done_dly = 3;
        core_mute = 1'b0;
        wait_idle(500, "to");
        exp_q.push_back({3'b001, m0[0]});
        exp_q.push_back({3'b010, m1[0]});
        exp_q.push_back({3'b010, m1[1]});
        exp_q.push_back({3'b010, 8'h0D});
        exp_q.push_back({3'b001, m0[1]});
        exp_q.push_back({3'b001, m0[2]});
        exp_q.push_back({3'b001, 8'h0D});
        check("to_err_count", 32'(n_timeout), 32'd1);
        check_sent("to");

        // Done pulsed during SEND is ignored
        do_reset(1);
        core_mute = 1'b1;
        push_one(0, 8'h41, 1'b1);
        clear_round();
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        extra_done = 1'b1;
        @(negedge clk);
        check("sd_send_aligned", 32'(obs_dv), 32'd1);
        @(posedge clk); #1;
        extra_done = 1'b0;
        wait_idle(100, "sd");
        check("sd_timeout", 32'(n_timeout), 32'd1);
        check("sd_sends", 32'(sent_q.size()), 32'd1);
        sent_q.delete();

        // Done coincides with the watchdog limit: done wins
        do_reset(1);
        done_dly = 16;
        push_msg(0, 1);
        model_round(1'b1);
        wait_idle(200, "lim");
        check("lim_no_err", 32'(n_timeout), 32'd0);
        check_sent("lim");

        // Reset asserted in WAIT
        do_reset(1);
        done_dly = 10;
        push_msg(0, 3);
        clear_round();
        ok = 0;
        for (int c = 0; c < 20 && ok == 0; c++) begin
            @(negedge clk);
            if (obs_dv) ok = 1;
        end
        check("rw_first_send", 32'(ok), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("rw");
        q0.delete();
        cyc(2);
        rst = 1'b0;
        cyc(40);
        check("rw_sends", 32'(sent_q.size()), 32'd1);
        check("rw_no_err", 32'(n_timeout), 32'd0);
        sent_q.delete();

        // APPEND_CR=0: single '#' byte, then a contention round
        do_reset(2);
        done_dly = 5;
        push_one(0, 8'h23, 1'b1);
        model_round(1'b0);
        wait_idle(100, "nocr1");
        check_sent("nocr1");
        for (int i = 0; i < N; i++) push_msg(i, $urandom_range(1, 4));
        model_round(1'b0);
        wait_idle(1000, "nocr2");
        check_sent("nocr2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
